// File: rtl/aes_seq_ctrl.sv
// ---------------------------------------------------------------------------
// aes_seq_ctrl
//
// Sequencing controller for the byte-serial AES core. It accepts 16 data bytes
// plus KB key bytes over an input valid/ready handshake. It then free-runs NR
// rounds of 16 cycles, driving the datapath and key-expansion strobes. Finally
// it presents 16 ciphertext bytes on an output valid/ready handshake that
// honours backpressure.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The side asserting valid holds it until that
// edge. in_ready depends only on state, never on in_valid. out_valid depends
// only on state, never on out_ready.
//
// Parameters:
//   KEY_BITS    128 / 192 / 256. Selects NR = 10 / 12 / 14 and KB = 16 / 24 / 32.
//   CNT_W       width of the load beat counter; must hold KB-1.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   start_i     request a new block; only looked at in IDLE
//   busy_o      high in every state except IDLE
//   in_valid_i  data/key byte pair present
//   in_ready_o  controller accepts a byte this cycle (LOAD, LOADK)
//   data_we_o   datapath captures the data byte (first 16 accepted beats)
//   key_we_o    key expansion captures the key byte (every accepted beat)
//   ks_phase_o  key-schedule phase: 0 LOAD, 1 B1ST, 2 B2ND, 3 B3RD, 4 NORM, 5 SHIF
//   rcon_o      current round constant
//   rcon_en_o   apply rcon/RotWord this cycle
//   sub_only_o  SubWord only (AES-256 even rounds)
//   rcon_col_o  column within the round for rcon_en/sub_only (0 otherwise)
//   round_o     round number 1..NR in ROUND, else 0
//   mc_en_o     MixColumns enable (rounds 1..NR-1)
//   pld_o       parallel-load strobe (cycles 3, 7, 11, 15 of each round)
//   out_valid_o ciphertext byte present
//   out_ready_i sink accepts a byte
//   done_o      one-cycle pulse after the 16th output byte is accepted
//   dbg_state_o current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module aes_seq_ctrl #(
    parameter int KEY_BITS = 128,
    parameter int CNT_W    = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             busy_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             data_we_o,
    output logic             key_we_o,
    output logic [2:0]       ks_phase_o,
    output logic [7:0]       rcon_o,
    output logic             rcon_en_o,
    output logic             sub_only_o,
    output logic [1:0]       rcon_col_o,
    output logic [3:0]       round_o,
    output logic             mc_en_o,
    output logic             pld_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             done_o,
    output logic [2:0]       dbg_state_o
);

    // -----------------------------------------------------------------------
    // Derived constants and elaboration checks
    // -----------------------------------------------------------------------
    localparam int NR = (KEY_BITS == 128) ? 10 :
                        (KEY_BITS == 192) ? 12 : 14;
    localparam int KB = KEY_BITS / 8;

    localparam logic [CNT_W-1:0] LAST_DATA_BEAT = CNT_W'(15);
    localparam logic [CNT_W-1:0] LAST_KEY_BEAT  = CNT_W'(KB - 1);
    localparam logic [3:0]       LAST_ROUND     = 4'(NR);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_seq_ctrl: KEY_BITS must be 128, 192 or 256");
    end

    if ((KB - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("aes_seq_ctrl: CNT_W too narrow to hold KB-1");
    end

    // Key-schedule phase codes
    localparam logic [2:0] PH_LOAD = 3'd0;
    localparam logic [2:0] PH_B1ST = 3'd1;
    localparam logic [2:0] PH_B2ND = 3'd2;
    localparam logic [2:0] PH_B3RD = 3'd3;
    localparam logic [2:0] PH_NORM = 3'd4;
    localparam logic [2:0] PH_SHIF = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_LOADK = 3'd2,
        S_ROUND = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    // GF(2^8) doubling used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_q,  beat_d;   // accepted load beats (data then key)
    logic [3:0]       cyc_q,   cyc_d;    // cycle within the current round
    logic [3:0]       round_q, round_d;  // current round, 1..NR
    logic [3:0]       obyte_q, obyte_d;  // output byte index
    logic [7:0]       rcon_q,  rcon_d;
    logic             done_q,  done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            cyc_q   <= '0;
            round_q <= '0;
            obyte_q <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cyc_q   <= cyc_d;
            round_q <= round_d;
            obyte_q <= obyte_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and strobes
    // -----------------------------------------------------------------------
    logic ev_col0;   // cycle where a column-0 key-schedule event lands
    logic ev_col2;   // cycle where a column-2 key-schedule event lands

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cyc_d       = cyc_q;
        round_d     = round_q;
        obyte_d     = obyte_q;
        rcon_d      = rcon_q;
        done_d      = 1'b0;

        in_ready_o  = 1'b0;
        data_we_o   = 1'b0;
        key_we_o    = 1'b0;
        ks_phase_o  = PH_LOAD;
        rcon_en_o   = 1'b0;
        sub_only_o  = 1'b0;
        rcon_col_o  = 2'd0;
        round_o     = 4'd0;
        mc_en_o     = 1'b0;
        pld_o       = 1'b0;
        out_valid_o = 1'b0;

        ev_col0     = (cyc_q == 4'd0);
        ev_col2     = (cyc_q == 4'd8);

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    beat_d  = '0;
                    rcon_d  = 8'h01;
                end
            end

            S_LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    data_we_o = 1'b1;
                    key_we_o  = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == LAST_DATA_BEAT) begin
                        if (KB == 16) begin
                            state_d = S_ROUND;
                            cyc_d   = 4'd0;
                            round_d = 4'd1;
                        end else begin
                            state_d = S_LOADK;
                        end
                    end
                end
            end

            // The beat counter carries on from 16, so the last key beat is KB-1.
            S_LOADK: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    key_we_o = 1'b1;
                    beat_d   = beat_q + 1'b1;
                    if (beat_q == LAST_KEY_BEAT) begin
                        state_d = S_ROUND;
                        cyc_d   = 4'd0;
                        round_d = 4'd1;
                    end
                end
            end

            S_ROUND: begin
                round_o = round_q;
                mc_en_o = (round_q != LAST_ROUND);
                pld_o   = (cyc_q[1:0] == 2'd3);

                if (cyc_q == 4'd0) begin
                    ks_phase_o = PH_B1ST;
                end else if (cyc_q <= 4'd2) begin
                    ks_phase_o = PH_B2ND;
                end else if (cyc_q == 4'd3) begin
                    ks_phase_o = PH_B3RD;
                end else if (cyc_q <= 4'd11) begin
                    ks_phase_o = PH_NORM;
                end else begin
                    ks_phase_o = PH_SHIF;
                end

                // Key-schedule events. AES-192 has six-word key blocks, so its
                // rcon lands at column 2 or column 0 on a three-round cycle.
                if (KEY_BITS == 128) begin
                    rcon_en_o = ev_col0;
                end else if (KEY_BITS == 256) begin
                    if (round_q[0]) begin
                        rcon_en_o = ev_col0;
                    end else begin
                        sub_only_o = ev_col0;
                    end
                end else begin
                    case (round_q)
                        4'd1, 4'd4, 4'd7, 4'd10: begin
                            rcon_en_o  = ev_col2;
                            rcon_col_o = ev_col2 ? 2'd2 : 2'd0;
                        end
                        4'd3, 4'd6, 4'd9, 4'd12: begin
                            rcon_en_o = ev_col0;
                        end
                        default: begin
                            rcon_en_o = 1'b0;
                        end
                    endcase
                end

                // The constant is consumed this cycle and stepped for the next event.
                if (rcon_en_o) begin
                    rcon_d = xtime(rcon_q);
                end

                cyc_d = cyc_q + 1'b1;
                if (cyc_q == 4'd15) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = S_OUT;
                        obyte_d = 4'd0;
                    end else begin
                        round_d = round_q + 1'b1;
                    end
                end
            end

            S_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    obyte_d = obyte_q + 1'b1;
                    if (obyte_q == 4'd15) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign rcon_o      = rcon_q;
    assign done_o      = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_seq_ctrl
//
// Three controllers (AES-128, AES-192, AES-256) share clock and reset and are
// exercised one at a time. Each table record describes one block: key size,
// input stall length, output backpressure, and the expected first-output and
// done cycles. The bench computes every strobe from its own round/cycle model
// against the cycle at which start was driven. Key-schedule events are pushed
// to exp_q when the block is started and popped whenever a DUT raises
// rcon_en or sub_only.
// ---------------------------------------------------------------------------
module tb_aes_seq_ctrl;

    logic clk;
    logic rst;

    logic       start_a     [3];
    logic       busy_a      [3];
    logic       in_valid_a  [3];
    logic       in_ready_a  [3];
    logic       data_we_a   [3];
    logic       key_we_a    [3];
    logic [2:0] ks_phase_a  [3];
    logic [7:0] rcon_a      [3];
    logic       rcon_en_a   [3];
    logic       sub_only_a  [3];
    logic [1:0] rcon_col_a  [3];
    logic [3:0] round_a     [3];
    logic       mc_en_a     [3];
    logic       pld_a       [3];
    logic       out_valid_a [3];
    logic       out_ready_a [3];
    logic       done_a      [3];
    logic [2:0] dbg_state_a [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_seq_ctrl #(
            .KEY_BITS (128 + 64 * g),
            .CNT_W    (5)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .start_i     (start_a[g]),
            .busy_o      (busy_a[g]),
            .in_valid_i  (in_valid_a[g]),
            .in_ready_o  (in_ready_a[g]),
            .data_we_o   (data_we_a[g]),
            .key_we_o    (key_we_a[g]),
            .ks_phase_o  (ks_phase_a[g]),
            .rcon_o      (rcon_a[g]),
            .rcon_en_o   (rcon_en_a[g]),
            .sub_only_o  (sub_only_a[g]),
            .rcon_col_o  (rcon_col_a[g]),
            .round_o     (round_a[g]),
            .mc_en_o     (mc_en_a[g]),
            .pld_o       (pld_a[g]),
            .out_valid_o (out_valid_a[g]),
            .out_ready_i (out_ready_a[g]),
            .done_o      (done_a[g]),
            .dbg_state_o (dbg_state_a[g])
        );
    end

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    int errors;
    int checks;

    // {sub_only, rcon_col[1:0], round[3:0], cycle[3:0], rcon[7:0]}
    logic [18:0] exp_q [$];

    logic [7:0] rcon_tab [10];
    logic [3:0] bp_pat;

    typedef struct {
        int k;          // 0: AES-128, 1: AES-192, 2: AES-256
        int stall;      // in_valid low for this many cycles after the 7th beat
        bit bp;         // out_ready pattern 1,0,0,1 plus start pulses during OUT
        int exp_first;  // first out_valid cycle relative to start
        int exp_done;   // done pulse cycle relative to start
        int exp_ev;     // rcon_en + sub_only pulses
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs(input int k);
        return {10'd0, dbg_state_a[k], busy_a[k], in_ready_a[k], data_we_a[k], key_we_a[k],
                ks_phase_a[k], rcon_en_a[k], sub_only_a[k], rcon_col_a[k], round_a[k],
                mc_en_a[k], pld_a[k], out_valid_a[k], done_a[k]};
    endfunction

    // -----------------------------------------------------------------------
    // Driver + per-cycle checks for one block
    // -----------------------------------------------------------------------
    task automatic push_events(input int k);
        int nr;
        int idx;
        nr  = 10 + 2 * k;
        idx = 0;
        exp_q.delete();
        for (int r = 1; r <= nr; r++) begin
            if (k == 0) begin
                exp_q.push_back({1'b0, 2'd0, 4'(r), 4'd0, rcon_tab[r-1]});
            end else if (k == 2) begin
                if (r % 2 == 1) exp_q.push_back({1'b0, 2'd0, 4'(r), 4'd0, rcon_tab[(r-1)/2]});
                else            exp_q.push_back({1'b1, 2'd0, 4'(r), 4'd0, 8'h00});
            end else begin
                if (r % 3 == 1) begin
                    exp_q.push_back({1'b0, 2'd2, 4'(r), 4'd8, rcon_tab[idx]});
                    idx++;
                end else if (r % 3 == 0) begin
                    exp_q.push_back({1'b0, 2'd0, 4'(r), 4'd0, rcon_tab[idx]});
                    idx++;
                end
            end
        end
    endtask

    task automatic run_block(input vec_t v);
        int k, kb, nr, rs, r, c;
        int n_data, n_key, n_ev, n_acc, n_done;
        logic [2:0]  eks;
        logic [8:0]  ectl;
        logic [18:0] exp_ev, act_ev;
        k  = v.k;
        kb = 16 + 8 * k;
        nr = 10 + 2 * k;
        rs = 1 + kb + v.stall;
        n_data = 0; n_key = 0; n_ev = 0; n_acc = 0; n_done = 0;
        push_events(k);

        for (int rel = 0; rel <= v.exp_done + 3; rel++) begin
            @(posedge clk); #1;
            start_a[k]     = (rel == 0) || (v.bp && (rel == v.exp_first + 5 || rel == v.exp_first + 6));
            in_valid_a[k]  = !(v.stall > 0 && rel >= 8 && rel < 8 + v.stall);
            out_ready_a[k] = v.bp ? bp_pat[(rel - v.exp_first) & 3] : 1'b1;
            @(negedge clk);

            chk("in_ready",  32'(in_ready_a[k]),  32'(rel >= 1 && rel <= kb + v.stall));
            chk("busy",      32'(busy_a[k]),      32'(rel >= 1 && rel < v.exp_done));
            chk("out_valid", 32'(out_valid_a[k]), 32'(rel >= v.exp_first && rel < v.exp_done));
            chk("done",      32'(done_a[k]),      32'(rel == v.exp_done));

            if (rel >= rs && rel < rs + 16 * nr) begin
                r   = (rel - rs) / 16 + 1;
                c   = (rel - rs) % 16;
                eks = (c == 0) ? 3'd1 : (c <= 2) ? 3'd2 : (c == 3) ? 3'd3 : (c <= 11) ? 3'd4 : 3'd5;
                ectl = {4'(r), eks, (c % 4 == 3), (r != nr)};
            end else begin
                r    = 0;
                c    = 15;
                ectl = 9'd0;
            end
            chk("round_ctl", 32'({round_a[k], ks_phase_a[k], pld_a[k], mc_en_a[k]}), 32'(ectl));

            if (rcon_en_a[k] || sub_only_a[k]) begin
                n_ev++;
                act_ev = {sub_only_a[k], rcon_col_a[k], round_a[k], 4'(c),
                          sub_only_a[k] ? 8'h00 : rcon_a[k]};
                if (exp_q.size() == 0) begin
                    chk("ks_event_unexpected", 32'(act_ev), 32'h7FFFF);
                end else begin
                    exp_ev = exp_q.pop_front();
                    chk("ks_event", 32'(act_ev), 32'(exp_ev));
                end
            end

            if (data_we_a[k]) n_data++;
            if (key_we_a[k])  n_key++;
            if (out_valid_a[k] && out_ready_a[k]) n_acc++;
            if (done_a[k]) n_done++;
        end
        start_a[k] = 1'b0;

        chk("data_we_count", 32'(n_data), 32'd16);
        chk("key_we_count",  32'(n_key),  32'(kb));
        chk("event_count",   32'(n_ev),   32'(v.exp_ev));
        chk("events_left",   32'(exp_q.size()), 32'd0);
        chk("out_accepted",  32'(n_acc),  32'd16);
        chk("done_count",    32'(n_done), 32'd1);
    endtask

    // -----------------------------------------------------------------------
    // Reset in the middle of round 5 on the AES-128 controller
    // -----------------------------------------------------------------------
    task automatic reset_mid_round();
        int n_done;
        n_done = 0;
        for (int rel = 0; rel <= 85; rel++) begin
            @(posedge clk); #1;
            start_a[0]     = (rel == 0);
            in_valid_a[0]  = 1'b1;
            out_ready_a[0] = 1'b1;
        end
        @(negedge clk);
        chk("mid_round_number", 32'(round_a[0]), 32'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_outs", outs(0), 32'd0);
        chk("after_rst_rcon", 32'(rcon_a[0]), 32'h01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_a[0] || busy_a[0]) n_done++;
        end
        chk("after_rst_quiet", 32'(n_done), 32'd0);
    endtask

    // -----------------------------------------------------------------------
    // Main sequence and report
    // -----------------------------------------------------------------------
    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bp_pat = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            start_a[k]     = 1'b0;
            in_valid_a[k]  = 1'b0;
            out_ready_a[k] = 1'b0;
        end

        rcon_tab[0] = 8'h01; rcon_tab[1] = 8'h02; rcon_tab[2] = 8'h04; rcon_tab[3] = 8'h08;
        rcon_tab[4] = 8'h10; rcon_tab[5] = 8'h20; rcon_tab[6] = 8'h40; rcon_tab[7] = 8'h80;
        rcon_tab[8] = 8'h1B; rcon_tab[9] = 8'h36;

        //        k  stall bp  first done ev
        vecs[0] = '{0, 0, 1'b0, 177, 193, 10};
        vecs[1] = '{2, 0, 1'b0, 257, 273, 14};
        vecs[2] = '{1, 0, 1'b0, 217, 233,  8};
        vecs[3] = '{0, 5, 1'b0, 182, 198, 10};
        vecs[4] = '{0, 0, 1'b1, 177, 209, 10};
        vecs[5] = '{1, 3, 1'b1, 220, 252,  8};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_outs", outs(k), 32'd0);
            chk("reset_rcon", 32'(rcon_a[k]), 32'h01);
        end

        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i]);
        end

        reset_mid_round();
        run_block(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_seq_ctrl.md
Name: aes_seq_ctrl

Overview:
Parametrised sequencing controller for the byte-serial AES core. It supports AES-128, AES-192 and AES-256, and adds valid/ready handshakes on both input and output, with backpressure on the output. It drives the datapath and key-expansion control strobes once per clock: load enables, key-schedule phase, rcon, MixColumns enable and parallel load. It sits between the top-level pins and the byte-serial datapath and key-expansion blocks, replacing the fixed 128-bit free-running sequencer.

Parameters:
KEY_BITS, 128, key length; legal values 128/192/256. NR = 10/12/14 rounds; KB = KEY_BITS/8 key bytes.
CNT_W, 5, width of the internal beat counter; must hold KB-1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  request a new block; sampled only in IDLE
busy  out  1  high in every state except IDLE
in_valid  in  1  a data/key byte pair is present on the pins
in_ready  out  1  controller accepts a byte this cycle
data_we  out  1  datapath captures the data byte (beat = in_valid & in_ready & first 16 beats)
key_we  out  1  key expansion captures the key byte (every accepted beat)
ks_phase  out  3  0 LOAD, 1 B1ST, 2 B2ND, 3 B3RD, 4 NORM, 5 SHIF
rcon  out  8  current round constant
rcon_en  out  1  apply rcon/RotWord this cycle
sub_only  out  1  SubWord without RotWord/rcon (AES-256 even rounds)
rcon_col  out  2  column within the round where rcon_en/sub_only applies
round  out  4  current round number, 1..NR; 0 outside ROUND
mc_en  out  1  MixColumns enable
pld  out  1  parallel-load strobe
out_valid  in/out n/a: see next line
out_valid  out  1  ciphertext byte present
out_ready  in  1  sink accepts a byte
done  out  1  one-cycle pulse after the 16th output byte is accepted

Behaviour:
- Reset values (synchronous reset, rst=1 at a clock edge): state=IDLE, all outputs 0, rcon=8'h01. rst mid-operation aborts immediately; no done pulse.
- States: IDLE, LOAD, LOADK, ROUND, OUT.
- IDLE:
  - start=1 -> LOAD next cycle.
  - start is ignored in all other states.
- LOAD:
  - in_ready=1.
  - Counts accepted beats; in_valid=0 stalls the count.
  - data_we and key_we are asserted on accepted beats.
  - After the 16th accepted beat: KEY_BITS=128 -> ROUND; otherwise -> LOADK.
- LOADK:
  - in_ready=1; key_we only, data_we=0.
  - Accepts KB-16 beats, then -> ROUND.
- ROUND:
  - Free-running, no stalls. in_ready=0.
  - Each round is 16 cycles, indexed by cycle c=0..15.
  - ks_phase by cycle: c=0 B1ST; c=1..2 B2ND; c=3 B3RD; c=4..11 NORM; c=12..15 SHIF.
  - round increments at c=0 of each round and starts at 1.
  - pld=1 at c=3,7,11,15.
  - mc_en=1 in rounds 1..NR-1; mc_en=0 for the whole of round NR.
  - rcon_en / rcon_col rules, pulsed for one cycle at cycle c = 4*rcon_col:
    - 128: every round, col 0.
    - 256: odd rounds, col 0; even rounds assert sub_only at col 0 instead.
    - 192: rounds 1,4,7,10 use col 2; rounds 3,6,9,12 use col 0; no event in other rounds.
  - rcon update: rcon <= xtime(rcon) on the cycle after each rcon_en. xtime is a left shift, XOR 8'h1B when bit 7 was set (sequence 01,02,04,...,80,1B,36).
  - rcon reloads to 8'h01 on entry to LOAD.
  - After c=15 of round NR -> OUT.
- OUT:
  - out_valid=1; a byte is consumed on out_valid & out_ready.
  - out_ready=0 holds state and the byte index.
  - After the 16th accepted byte: done=1 for 1 cycle, state -> IDLE, busy=0 that same cycle.
- Latency with no stalls, start sampled at cycle T (first load beat T+1): first out_valid at T+177 (128), T+217 (192), T+257 (256).
- round, rcon_en, sub_only, mc_en and pld are 0 outside ROUND. ks_phase=0 outside ROUND.
- An illegal KEY_BITS value is an elaboration-time error.

Test Plan:
- KEY_BITS=128: start at T, in_valid held high, out_ready high -> in_ready high for exactly T+1..T+16, first out_valid at T+177, done at T+193, rcon_en seen 10 times with rcon 01,02,...,36.
- KEY_BITS=256: as above -> data_we on 16 beats, key_we on 32, out_valid at T+257, rcon_en in rounds 1,3,...,13 (7 pulses, rcon 01..40), sub_only in rounds 2,4,...,14.
- KEY_BITS=192: rcon_en at c=8 in rounds 1,4,7,10 and at c=0 in rounds 3,6,9,12; 8 pulses total, final rcon value used is 8'h80.
- Input stall: deassert in_valid for 5 cycles after the 7th beat -> first out_valid shifts by exactly 5 cycles, beat count is unchanged.
- Output backpressure: out_ready toggled 1,0,0,1 repeating -> exactly 16 accepted bytes, done only after the 16th, start pulsed during OUT is ignored.
- Reset mid-ROUND (round=5): rst=1 for one edge -> next cycle IDLE, all outputs 0, rcon=8'h01, no done; a following start runs a full block normally.
